dmem_arbiter_mips: RTL and testbench
====================================

# dmem_arbiter_mips

Arbitrates the single-port MIPS data memory between the CPU datapath and a debug/DMA burst port. It uses a two-state FSM, bounded-starvation arbitration and auto-incrementing debug bursts. The block sits between the datapath/control unit (address, write data, write enable) and the data memory. It returns read data to whichever requester owns the port and stalls the CPU while a debug burst holds the memory.

## Interface
Parameters:
- `mem_add_width`, 32: byte address width on both sides.
- `mem_width`, 32: data word width.
- `len_width`, 8: width of the burst-length field; a burst is `dbg_len+1` words.
- `max_wait`, 4: number of CPU-granted contended cycles before debug is forced in; 0 gives debug strict priority.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `cpu_req`, in, 1: CPU memory access this cycle (lw/sw).
- `cpu_wr`, in, 1: CPU write (sw).
- `cpu_addr`, in, `mem_add_width`: CPU byte address (ALU result).
- `cpu_wdata`, in, `mem_width`: CPU store data.
- `cpu_rdata`, out, `mem_width`: load data to the datapath.
- `cpu_stall`, out, 1: freeze PC and register write this cycle.
- `dbg_req`, in, 1: debug burst request (level).
- `dbg_wr`, in, 1: burst direction, 1 = write. Latched at grant.
- `dbg_addr`, in, `mem_add_width`: burst base address. Latched at grant; bits [1:0] are forced to 0.
- `dbg_len`, in, `len_width`: beats minus one. Latched at grant.
- `dbg_wdata`, in, `mem_width`: write data for the current beat.
- `dbg_ack`, out, 1: a beat executes this cycle.
- `dbg_rdata`, out, `mem_width`: read data for the current beat, valid while `dbg_ack` is high.
- `dbg_done`, out, 1: high on the last beat.
- `mem_wr_en`, out, 1: data-memory write enable.
- `mem_addr`, out, `mem_add_width`: data-memory address.
- `mem_wdata`, out, `mem_width`: data-memory write data.
- `mem_rdata`, in, `mem_width`: data-memory read data. The memory read is combinational.

## Operation
- States:
  - S_CPU: CPU owns the port. This is the reset state.
  - S_DBG: a debug burst is in progress.
- S_CPU datapath:
  - `mem_addr`/`mem_wdata` come from the CPU.
  - `mem_wr_en = cpu_req & cpu_wr`.
  - `cpu_rdata = mem_rdata`.
  - `cpu_stall = 0`; `dbg_ack = dbg_done = 0`.
- `wait_cnt` (S_CPU only):
  - Increments each cycle `dbg_req & cpu_req`, saturating at `max_wait`.
  - Cleared when `dbg_req = 0` or on grant.
- Grant: S_CPU→S_DBG at the clock edge when `dbg_req & (!cpu_req | wait_cnt == max_wait)`. At that edge, latch:
  - `base = {dbg_addr[..:2], 2'b00}`
  - `len = dbg_len`
  - `dir = dbg_wr`
  - `beat = 0`
- S_DBG, every cycle:
  - Exactly one beat executes.
  - `mem_addr = base + 4*beat`, truncated to `mem_add_width` (wraps modulo 2^`mem_add_width`).
  - `mem_wr_en = dir`; `mem_wdata = dbg_wdata`.
  - `dbg_ack = 1`; `dbg_rdata = mem_rdata`.
  - `beat` increments at the edge.
- Stall and blocking in S_DBG:
  - `cpu_stall = cpu_req`. Non-memory instructions proceed.
  - CPU writes never reach memory.
  - `cpu_rdata` is don't-care and is driven 0.
- Burst end: when `beat == len`, `dbg_done = 1` and the FSM returns to S_CPU at that edge.
- Deasserting `dbg_req` mid-burst is ignored; the burst always completes.
- After a burst the FSM spends at least one cycle in S_CPU before any re-grant, so the CPU is guaranteed progress.

## Timing
- Reset (`rst = 0` at an edge):
  - State S_CPU; `wait_cnt`, `beat` and the latches are 0.
  - Next cycle's outputs: `cpu_stall = 0`, `dbg_ack = 0`, `dbg_done = 0`, `mem_wr_en = cpu_req & cpu_wr`.
- Reset mid-burst aborts the burst. No debug write occurs in any cycle after the reset edge.
- Grant latency:
  - Uncontended (`cpu_req = 0`): first beat occurs the cycle after `dbg_req` is sampled.
  - Contended (CPU accessing every cycle): the CPU receives `max_wait+1` accesses, then the first debug beat follows.
- Burst occupancy: exactly `len+1` consecutive cycles. No bubbles, no back-pressure.
- Simultaneous `cpu_req` and `dbg_req` in the grant cycle: the CPU access completes in that cycle and debug starts next cycle.
- All outputs are combinational from state and inputs. No output registers.

## Structure
- Package `mips_arb_pkg`:
  - State enum {S_CPU, S_DBG}.
  - Word-offset constant 4.
  - Default widths.
- Sub-module `arb_wait_ctr`: saturating starvation counter with clear, increment, saturate-at-`max_wait` and `hit` output.
- Everything else lives in the top FSM.

## Test plan
- Reset: hold `rst = 0` for 2 cycles with `cpu_req = 1`, `cpu_wr = 1`, `cpu_addr = 0x10` → `cpu_stall = 0`, `dbg_ack = 0`, `mem_wr_en = 1`, `mem_addr = 0x10`.
- Uncontended write burst: `dbg_req = 1`, `dbg_wr = 1`, `dbg_addr = 0x23`, `dbg_len = 3`, `cpu_req = 0`.
  - Writes to 0x20, 0x24, 0x28, 0x2C on 4 consecutive cycles.
  - `dbg_done` on the 4th beat.
- Starvation bound: `cpu_req = 1` every cycle, `max_wait = 4`, `dbg_req` raised at cycle 0.
  - CPU served cycles 0–4.
  - `cpu_stall = 1` and `dbg_ack = 1` from cycle 5.
- CPU store blocked: issue `cpu_wr` to 0x40 with data 0xDEAD during S_DBG.
  - Memory at 0x40 is unchanged.
  - `cpu_stall = 1` until the burst ends.
- Read burst and wrap: `dbg_addr = 0xFFFFFFFC`, `dbg_len = 1`, `dbg_wr = 0`.
  - Addresses 0xFFFFFFFC then 0x00000000.
  - `dbg_rdata` matches memory contents on each beat.
- Reset mid-burst: drive `rst = 0` on beat 2 of an 8-beat write.
  - Only beats 0–1 are written.
  - State returns to S_CPU and `dbg_ack = 0` next cycle.

Source files
------------

// File: rtl/dmem_arbiter_mips_pkg.sv
// Shared types and defaults for the MIPS data-memory arbiter.
// Imported by the interface, the wait counter and the top FSM.
package mips_arb_pkg;

   typedef enum logic {
      S_CPU = 1'b0,
      S_DBG = 1'b1
   } arb_state_t;

   localparam int WORD_OFS     = 4;
   localparam int DEF_ADD_W    = 32;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_LEN_W    = 8;
   localparam int DEF_MAX_WAIT = 4;

   // Counter width able to hold 0..m, never narrower than one bit.
   function automatic int cnt_w(input int m);
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/dmem_arbiter_mips_if.sv
// Bus bundle between the requesters/memory and the arbiter.
// master = CPU, debug port and memory; slave = the arbiter.
interface dmem_arbiter_mips_if
   import mips_arb_pkg::*;
#(
   parameter int mem_add_width = DEF_ADD_W,
   parameter int mem_width     = DEF_DATA_W,
   parameter int len_width     = DEF_LEN_W
);

   logic                     cpu_req;
   logic                     cpu_wr;
   logic [mem_add_width-1:0] cpu_addr;
   logic [mem_width-1:0]     cpu_wdata;
   logic [mem_width-1:0]     cpu_rdata;
   logic                     cpu_stall;

   logic                     dbg_req;
   logic                     dbg_wr;
   logic [mem_add_width-1:0] dbg_addr;
   logic [len_width-1:0]     dbg_len;
   logic [mem_width-1:0]     dbg_wdata;
   logic                     dbg_ack;
   logic [mem_width-1:0]     dbg_rdata;
   logic                     dbg_done;

   logic                     mem_wr_en;
   logic [mem_add_width-1:0] mem_addr;
   logic [mem_width-1:0]     mem_wdata;
   logic [mem_width-1:0]     mem_rdata;

   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dbg_req, dbg_wr, dbg_addr, dbg_len, dbg_wdata,
      input  dbg_ack, dbg_rdata, dbg_done,
      input  mem_wr_en, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dbg_req, dbg_wr, dbg_addr, dbg_len, dbg_wdata,
      output dbg_ack, dbg_rdata, dbg_done,
      output mem_wr_en, mem_addr, mem_wdata,
      input  mem_rdata
   );

endinterface

// File: rtl/dmem_arbiter_mips_arb_wait_ctr.sv
// Saturating starvation counter: counts contended CPU-won cycles.
// hit rises once max_wait cycles have been granted to the CPU.
module arb_wait_ctr
   import mips_arb_pkg::*;
#(
   parameter int max_wait = DEF_MAX_WAIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   localparam int CW = cnt_w(max_wait);

   logic [CW-1:0] cnt;

   assign hit = (cnt == CW'(max_wait));

   // Clear wins over increment; hold once saturated.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !hit) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dmem_arbiter_mips.sv
// Single-port data-memory arbiter: CPU datapath vs. debug bursts.
// Debug wins after bounded CPU starvation and bursts run to completion.
module dmem_arbiter_mips
   import mips_arb_pkg::*;
#(
   parameter int mem_add_width = DEF_ADD_W,
   parameter int mem_width     = DEF_DATA_W,
   parameter int len_width     = DEF_LEN_W,
   parameter int max_wait      = DEF_MAX_WAIT
) (
   input logic             clk,
   input logic             rst,
   dmem_arbiter_mips_if.slave bus
);

   arb_state_t               state;
   logic [mem_add_width-1:0] base;
   logic [len_width-1:0]     len;
   logic                     dir;
   logic [len_width-1:0]     beat;

   logic                     in_cpu;
   logic                     hit;
   logic                     grant;
   logic                     last;
   logic [mem_add_width-1:0] beat_ofs;

   assign in_cpu   = (state == S_CPU);
   assign grant    = in_cpu & bus.dbg_req & (~bus.cpu_req | hit);
   assign last     = (beat == len);
   assign beat_ofs = mem_add_width'(beat)
                   * mem_add_width'(WORD_OFS);

   arb_wait_ctr #(
      .max_wait (max_wait)
   ) u_wait (
      .clk (clk),
      .rst (rst),
      .clr (~in_cpu | ~bus.dbg_req | grant),
      .inc (in_cpu & bus.dbg_req & bus.cpu_req),
      .hit (hit)
   );

   // Ownership FSM; burst parameters are captured at the grant edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_CPU;
         base  <= '0;
         len   <= '0;
         dir   <= 1'b0;
         beat  <= '0;
      end else begin
         unique case (state)
            S_CPU: begin
               if (grant) begin
                  state <= S_DBG;
                  base  <= {bus.dbg_addr[mem_add_width-1:2], 2'b00};
                  len   <= bus.dbg_len;
                  dir   <= bus.dbg_wr;
                  beat  <= '0;
               end
            end
            S_DBG: begin
               beat <= beat + 1'b1;
               if (last) begin
                  state <= S_CPU;
               end
            end
            default: state <= S_CPU;
         endcase
      end
   end

   // Memory steering; a reset during a beat suppresses its write.
   always_comb begin
      bus.mem_wr_en = 1'b0;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.cpu_rdata = '0;
      bus.cpu_stall = 1'b0;
      bus.dbg_ack   = 1'b0;
      bus.dbg_rdata = '0;
      bus.dbg_done  = 1'b0;
      unique case (state)
         S_CPU: begin
            bus.mem_wr_en = bus.cpu_req & bus.cpu_wr;
            bus.cpu_rdata = bus.mem_rdata;
         end
         S_DBG: begin
            bus.mem_wr_en = dir & rst;
            bus.mem_addr  = base + beat_ofs;
            bus.mem_wdata = bus.dbg_wdata;
            bus.cpu_stall = bus.cpu_req;
            bus.dbg_ack   = 1'b1;
            bus.dbg_rdata = bus.mem_rdata;
            bus.dbg_done  = last;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter_mips.sv
// Directed bench for dmem_arbiter_mips with a 256-word memory model.
// Expected values are hand-computed from the arbiter behaviour.
module tb_dmem_arbiter_mips;
   import mips_arb_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [31:0] mem [256];

   dmem_arbiter_mips_if #(
      .mem_add_width (32),
      .mem_width     (32),
      .len_width     (8)
   ) bus ();

   dmem_arbiter_mips #(
      .mem_add_width (32),
      .mem_width     (32),
      .len_width     (8),
      .max_wait      (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

   // Memory model: synchronous write, combinational read.
   always @(posedge clk) begin
      if (bus.mem_wr_en) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      rst           = 1'b0;
      bus.cpu_req   = 1'b1;
      bus.cpu_wr    = 1'b1;
      bus.cpu_addr  = 32'h10;
      bus.cpu_wdata = 32'h55;
      bus.dbg_req   = 1'b0;
      bus.dbg_wr    = 1'b0;
      bus.dbg_addr  = '0;
      bus.dbg_len   = '0;
      bus.dbg_wdata = '0;

      // Reset held two cycles with a CPU store pending.
      step();
      step();
      check("rst_stall", 32'(bus.cpu_stall), 32'd0);
      check("rst_ack",   32'(bus.dbg_ack),   32'd0);
      check("rst_done",  32'(bus.dbg_done),  32'd0);
      check("rst_wren",  32'(bus.mem_wr_en), 32'd1);
      check("rst_addr",  bus.mem_addr,       32'h10);
      rst         = 1'b1;
      bus.cpu_req = 1'b0;
      bus.cpu_wr  = 1'b0;
      step();

      // Uncontended write burst from unaligned base 0x23.
      bus.dbg_req  = 1'b1;
      bus.dbg_wr   = 1'b1;
      bus.dbg_addr = 32'h23;
      bus.dbg_len  = 8'd3;
      settle();
      check("wb_pre_ack", 32'(bus.dbg_ack), 32'd0);
      step();
      for (int b = 0; b < 4; b++) begin
         bus.dbg_wdata = 32'hA000 + b;
         if (b == 1) bus.dbg_req = 1'b0;
         settle();
         check("wb_ack",  32'(bus.dbg_ack),   32'd1);
         check("wb_wren", 32'(bus.mem_wr_en), 32'd1);
         check("wb_addr", bus.mem_addr,       32'h20 + 4 * b);
         check("wb_wd",   bus.mem_wdata,      32'hA000 + b);
         check("wb_done", 32'(bus.dbg_done),  (b == 3) ? 32'd1 : 32'd0);
         step();
      end
      check("wb_end_ack", 32'(bus.dbg_ack), 32'd0);
      for (int b = 0; b < 4; b++)
         check("wb_mem", mem[8 + b], 32'hA000 + b);

      // Contended: CPU loads every cycle, debug forced in at cycle 5.
      bus.cpu_req  = 1'b1;
      bus.cpu_wr   = 1'b0;
      bus.cpu_addr = 32'h80;
      bus.dbg_req  = 1'b1;
      bus.dbg_wr   = 1'b1;
      bus.dbg_addr = 32'h100;
      bus.dbg_len  = 8'd1;
      for (int c = 0; c < 5; c++) begin
         settle();
         check("sv_stall", 32'(bus.cpu_stall), 32'd0);
         check("sv_ack",   32'(bus.dbg_ack),   32'd0);
         check("sv_rdata", bus.cpu_rdata,      32'h1000_0020);
         step();
      end

      // CPU store to 0x40 attempted while the burst owns memory.
      bus.cpu_wr    = 1'b1;
      bus.cpu_addr  = 32'h40;
      bus.cpu_wdata = 32'hDEAD;
      for (int b = 0; b < 2; b++) begin
         bus.dbg_wdata = 32'hC000 + b;
         if (b == 1) bus.dbg_req = 1'b0;
         settle();
         check("blk_stall", 32'(bus.cpu_stall), 32'd1);
         check("blk_ack",   32'(bus.dbg_ack),   32'd1);
         check("blk_addr",  bus.mem_addr,       32'h100 + 4 * b);
         check("blk_wd",    bus.mem_wdata,      32'hC000 + b);
         check("blk_rd",    bus.cpu_rdata,      32'd0);
         check("blk_done",  32'(bus.dbg_done),  (b == 1) ? 32'd1 : 32'd0);
         step();
      end
      bus.cpu_wr = 1'b0;
      settle();
      check("blk_end_stall", 32'(bus.cpu_stall), 32'd0);
      check("blk_mem40", mem[16], 32'h1000_0010);
      check("blk_mem100", mem[64], 32'hC000);
      check("blk_mem104", mem[65], 32'hC001);
      bus.cpu_req = 1'b0;
      step();

      // Read burst wrapping past the top of the address space.
      bus.dbg_req  = 1'b1;
      bus.dbg_wr   = 1'b0;
      bus.dbg_addr = 32'hFFFF_FFFC;
      bus.dbg_len  = 8'd1;
      step();
      bus.dbg_req = 1'b0;
      settle();
      check("rd0_addr", bus.mem_addr,       32'hFFFF_FFFC);
      check("rd0_wren", 32'(bus.mem_wr_en), 32'd0);
      check("rd0_data", bus.dbg_rdata,      32'h1000_00FF);
      check("rd0_done", 32'(bus.dbg_done),  32'd0);
      step();
      check("rd1_addr", bus.mem_addr,       32'h0);
      check("rd1_data", bus.dbg_rdata,      32'h1000_0000);
      check("rd1_done", 32'(bus.dbg_done),  32'd1);
      step();
      check("rd_end_ack", 32'(bus.dbg_ack), 32'd0);

      // Reset during beat 2 of an 8-beat write burst.
      bus.dbg_req  = 1'b1;
      bus.dbg_wr   = 1'b1;
      bus.dbg_addr = 32'h200;
      bus.dbg_len  = 8'd7;
      step();
      for (int b = 0; b < 3; b++) begin
         bus.dbg_wdata = 32'hB0 + b;
         if (b == 2) rst = 1'b0;
         settle();
         check("mr_ack", 32'(bus.dbg_ack), 32'd1);
         check("mr_wren", 32'(bus.mem_wr_en), (b == 2) ? 32'd0 : 32'd1);
         step();
      end
      check("mr_after_ack", 32'(bus.dbg_ack), 32'd0);
      check("mr_after_wren", 32'(bus.mem_wr_en), 32'd0);
      bus.dbg_req = 1'b0;
      rst         = 1'b1;
      step();
      check("mr_idle_ack", 32'(bus.dbg_ack), 32'd0);
      check("mr_mem0", mem[128], 32'hB0);
      check("mr_mem1", mem[129], 32'hB1);
      check("mr_mem2", mem[130], 32'h1000_0082);
      check("mr_mem3", mem[131], 32'h1000_0083);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
